ddr4_cmd_issuer: RTL and testbench
==================================

# ddr4_cmd_issuer

Controller-side DDR4 command generator: turns single read/write requests into DES/ACT/PRE/PREA/RD/RDA/WR/WRA/REF sequences on the DIMM command pins (cs_n, act_n, A, bg, ba). It keeps an open-page bank table, enforces the configured spacing between commands, and schedules periodic refresh. It sits between the host request port and the DIMM model's command/address inputs.

## Interface
- RANKS, 1, cs_n width; commands always target rank 0
- BGWIDTH, 2, bank-group address bits
- BAWIDTH, 2, bank address bits
- ADDRWIDTH, 17, A width; must be ≥17 because A16/A15/A14 are ras_n/cas_n/we_n
- COLWIDTH, 10, column bits; must be ≤10
- TRCD, 14, ACT→RD/WR cycles
- TRP, 14, PRE/PREA/auto-precharge→next command cycles
- TRAS, 32, minimum ACT→PRE cycles for the same bank
- TCCD, 4, RD/WR→next command cycles
- TRFC, 260, REF→next command cycles
- TREFI, 7800, cycles between refresh requests
- All timing parameters are 1..65535.

Ports (clock and reset first):
- clk  in  1  sole clock; everything is on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the edge where valid&&ready
- req_write  in  1  1=write, 0=read
- req_bg  in  BGWIDTH  target bank group
- req_ba  in  BAWIDTH  target bank
- req_row  in  ADDRWIDTH  row address
- req_col  in  COLWIDTH  column address
- req_ap  in  1  auto-precharge (RDA/WRA)
- cs_n  out  RANKS  chip select, active-low
- act_n  out  1  activate, active-low
- A  out  ADDRWIDTH  row, column, or command pins
- bg  out  BGWIDTH  bank group
- ba  out  BAWIDTH  bank
- rd_issue  out  1  one-cycle pulse, aligned with the RD/RDA pin cycle
- wr_issue  out  1  one-cycle pulse, aligned with the WR/WRA pin cycle

## Operation
- All pin outputs are registered.
- Reset and idle values (DES): cs_n all 1, act_n=1, A=0, bg=0, ba=0, rd_issue=0, wr_issue=0, req_ready=0 during reset.
- Encodings, all with cs_n[0]=0:
  - ACT: act_n=0, A=row.
  - Otherwise act_n=1, A16/15/14 as follows:
    - PRE 010, A10=0
    - PREA 010, A10=1
    - RD 101
    - WR 100
    - REF 001
  - For RD/WR: A[COLWIDTH-1:0]=col, A10=ap, A12=1 (BL8), other bits 0.
- Bank table, one entry per {bg,ba}: open flag, open row, and a tRAS counter that counts up from ACT and saturates.
- Global wait_cnt: loaded when a command issues, with the gap that must pass before the next command:
  - ACT→TRCD
  - RD/WR→TCCD
  - RDA/WRA→TRP (bank marked closed)
  - PRE/PREA→TRP
  - REF→TRFC
- A command issues only when wait_cnt==0. This gives exactly tX cycles between issue edges.
- FSM states: IDLE, PRE, ACT, CAS, PREA, REF.
  - IDLE: req_ready=1 only if ref_pending=0. On accept, latch the request, then:
    - open row hit → CAS
    - different row open → PRE
    - bank closed → ACT
  - PRE: waits for wait_cnt==0 and tRAS satisfied for the bank, issues PRE, → ACT.
  - ACT: issues ACT, → CAS.
  - CAS: issues RD/WR, pulses rd_issue/wr_issue, → IDLE.
- Refresh:
  - ref_cnt counts 0..TREFI-1; at wrap it sets ref_pending.
  - In IDLE, refresh takes priority over a simultaneous req_valid.
  - Sequence: if any bank is open, PREA (waits until all open banks satisfy tRAS), then REF. Otherwise REF directly.
  - REF clears ref_pending.
- PREA and RDA/WRA clear the open flags.
- A refresh that falls due mid-request waits until the request's CAS completes.

## Timing
- Closed bank, wait_cnt=0, request accepted at edge 0: ACT on pins after edge 1, RD/WR after edge 1+TRCD.
- Row hit accepted at edge 0: CAS after edge max(1, edge where wait_cnt reaches 0).
- Row miss: PRE no earlier than TRAS after that bank's ACT edge. ACT follows TRP after PRE. CAS follows TRCD after ACT.
- req_ready drops the cycle after accept and returns in IDLE. At most one request is outstanding.
- Reset asserted mid-sequence: on the next edge, DES outputs, FSM=IDLE, bank table cleared, wait_cnt=0, ref_cnt=0, ref_pending=0, latched request discarded.

## Structure
- Package ddr4_cmd_pkg holds:
  - cmd_t enum (DES, ACT, PRE, PREA, RD, RDA, WR, WRA, REF)
  - state_t enum
  - A16:14 encoding constants
  - a function that maps cmd_t to pin values
- Sub-module ddr4_bank_tracker holds the per-bank open flag, row, and saturating tRAS counters. It has open/close/close-all strobes and lookup outputs.

## Test plan
- Reset, then read bg=1 ba=2 row=0x1A5 col=0x3C ap=0, accepted at edge 0:
  - ACT after edge 1 with act_n=0, A=0x001A5, bg=1, ba=2.
  - RD after edge 15 with A16:14=101, A10=0, A12=1, A[9:0]=0x3C, rd_issue=1 for one cycle.
  - DES in every other cycle.
- Write to the same row immediately after: WR exactly 4 cycles after RD, wr_issue pulses, no ACT.
- Read to row 0x2 in the same bank: PRE 32 cycles after the original ACT, ACT 14 cycles later, RD 14 cycles after that.
- With TREFI=64 and one bank open, hold req_valid:
  - req_ready=0 while ref_pending.
  - PREA (A10=1), then REF 14 cycles later, then no command for 260 cycles.
  - Request serviced after that.
- Read with ap=1 then a read to the same bank: no PRE issued, ACT 14 cycles after RDA.
- Assert reset for one cycle between ACT and RD: DES thereafter, req_ready=1 after release, and the next request to the same bank starts with ACT.

Source files
------------

// File: rtl/ddr4_cmd_pkg.sv
// Shared types and pin encodings for the DDR4 command issuer.
// Holds the command/state enums and the command-to-pin mapping.
package ddr4_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_DES,
        CMD_ACT,
        CMD_PRE,
        CMD_PREA,
        CMD_RD,
        CMD_RDA,
        CMD_WR,
        CMD_WRA,
        CMD_REF
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_CAS,
        S_PREA,
        S_REF
    } state_t;

    // A16/A15/A14 = ras_n/cas_n/we_n
    localparam logic [2:0] RCW_PRE = 3'b010;
    localparam logic [2:0] RCW_RD  = 3'b101;
    localparam logic [2:0] RCW_WR  = 3'b100;
    localparam logic [2:0] RCW_REF = 3'b001;

    typedef struct packed {
        logic        sel;
        logic        act_n;
        logic [16:0] a;
    } pins_t;

    // Low 17 address pins for a command; the ACT row is inserted
    // by the caller since its width is a module parameter.
    function automatic pins_t cmd_pins(cmd_t cmd, logic [9:0] col);
        pins_t p;
        p.sel   = 1'b1;
        p.act_n = 1'b1;
        p.a     = '0;
        case (cmd)
            CMD_ACT: p.act_n = 1'b0;
            CMD_PRE: p.a[16:14] = RCW_PRE;
            CMD_PREA: begin
                p.a[16:14] = RCW_PRE;
                p.a[10]    = 1'b1;
            end
            CMD_RD, CMD_RDA: begin
                p.a[16:14] = RCW_RD;
                p.a[12]    = 1'b1;
                p.a[10]    = (cmd == CMD_RDA);
                p.a[9:0]   = col;
            end
            CMD_WR, CMD_WRA: begin
                p.a[16:14] = RCW_WR;
                p.a[12]    = 1'b1;
                p.a[10]    = (cmd == CMD_WRA);
                p.a[9:0]   = col;
            end
            CMD_REF: p.a[16:14] = RCW_REF;
            default: p.sel = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ddr4_bank_tracker.sv
// Open-page table: per {bg,ba} open flag, open row and a tRAS
// counter. Ports: open/close/close-all strobes, lookup outputs.
module ddr4_bank_tracker
    import ddr4_cmd_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int TRAS      = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         open_i,
    input  logic [BGWIDTH+BAWIDTH-1:0]   open_idx_i,
    input  logic [ADDRWIDTH-1:0]         open_row_i,
    input  logic                         close_i,
    input  logic [BGWIDTH+BAWIDTH-1:0]   close_idx_i,
    input  logic                         close_all_i,
    input  logic [BGWIDTH+BAWIDTH-1:0]   look_idx_i,
    output logic                         look_open_o,
    output logic [ADDRWIDTH-1:0]         look_row_o,
    output logic                         look_tras_ok_o,
    output logic                         any_open_o,
    output logic                         all_tras_ok_o
);

    localparam int IDXW = BGWIDTH + BAWIDTH;
    localparam int NB   = 1 << IDXW;
    localparam logic [15:0] TRAS_SAT = 16'(TRAS);

    logic                 open_q [NB];
    logic [ADDRWIDTH-1:0] row_q  [NB];
    logic [15:0]          tras_q [NB];

    // tras_q is loaded with 1 on ACT, so before the edge k cycles
    // after ACT it reads k; PRE is legal once it reaches TRAS.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NB; i++) begin
                open_q[i] <= 1'b0;
                row_q[i]  <= '0;
                tras_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (tras_q[i] < TRAS_SAT)
                    tras_q[i] <= tras_q[i] + 16'd1;
                if (close_all_i || (close_i && close_idx_i == IDXW'(i)))
                    open_q[i] <= 1'b0;
                if (open_i && open_idx_i == IDXW'(i)) begin
                    open_q[i] <= 1'b1;
                    row_q[i]  <= open_row_i;
                    tras_q[i] <= 16'd1;
                end
            end
        end
    end

    assign look_open_o    = open_q[look_idx_i];
    assign look_row_o     = row_q[look_idx_i];
    assign look_tras_ok_o = tras_q[look_idx_i] >= TRAS_SAT;

    always_comb begin
        any_open_o    = 1'b0;
        all_tras_ok_o = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (open_q[i]) begin
                any_open_o = 1'b1;
                if (tras_q[i] < TRAS_SAT)
                    all_tras_ok_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ddr4_cmd_issuer.sv
// DDR4 command generator: one request at a time -> PRE/ACT/CAS, plus
// periodic PREA/REF. Ports: host req_* handshake, registered DIMM pins.
module ddr4_cmd_issuer
    import ddr4_cmd_pkg::*;
#(
    parameter int RANKS     = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRCD      = 14,
    parameter int TRP       = 14,
    parameter int TRAS      = 32,
    parameter int TCCD      = 4,
    parameter int TRFC      = 260,
    parameter int TREFI     = 7800
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    input  logic                 req_ap,
    output logic [RANKS-1:0]     cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 rd_issue,
    output logic                 wr_issue
);

    localparam int IDXW = BGWIDTH + BAWIDTH;
    // Gaps are loaded minus one so issue edges are exactly tX apart.
    localparam logic [15:0] W_TRCD  = 16'(TRCD - 1);
    localparam logic [15:0] W_TRP   = 16'(TRP - 1);
    localparam logic [15:0] W_TCCD  = 16'(TCCD - 1);
    localparam logic [15:0] W_TRFC  = 16'(TRFC - 1);
    localparam logic [15:0] REFI_LAST = 16'(TREFI - 1);

    state_t               state_q, state_d;
    logic [15:0]          wait_q, wait_d;
    logic [15:0]          ref_cnt_q;
    logic                 ref_pend_q;

    logic                 lat_wr_q, lat_ap_q;
    logic [BGWIDTH-1:0]   lat_bg_q;
    logic [BAWIDTH-1:0]   lat_ba_q;
    logic [ADDRWIDTH-1:0] lat_row_q;
    logic [COLWIDTH-1:0]  lat_col_q;

    logic [RANKS-1:0]     cs_n_q, cs_n_d;
    logic                 act_n_q;
    logic [ADDRWIDTH-1:0] a_q, a_d;
    logic [BGWIDTH-1:0]   bg_q;
    logic [BAWIDTH-1:0]   ba_q;
    logic                 rd_q, wr_q;

    cmd_t                 cmd;
    pins_t                pins;
    logic [9:0]           col_ext;
    logic                 accept, wait_zero, bank_cmd;
    logic                 bank_open, bank_close, close_all, clr_pend;
    logic [IDXW-1:0]      look_idx;
    logic                 look_open, look_tras_ok;
    logic                 any_open, all_tras_ok;
    logic [ADDRWIDTH-1:0] look_row;

    assign req_ready = (state_q == S_IDLE) && !ref_pend_q && !reset;
    assign accept    = req_valid && req_ready;
    assign wait_zero = (wait_q == 16'd0);
    // IDLE classifies the incoming request; later states use the latch.
    assign look_idx  = (state_q == S_IDLE) ? {req_bg, req_ba}
                                           : {lat_bg_q, lat_ba_q};

    ddr4_bank_tracker #(
        .BGWIDTH   (BGWIDTH),
        .BAWIDTH   (BAWIDTH),
        .ADDRWIDTH (ADDRWIDTH),
        .TRAS      (TRAS)
    ) u_banks (
        .clk_i          (clk),
        .reset_i        (reset),
        .open_i         (bank_open),
        .open_idx_i     ({lat_bg_q, lat_ba_q}),
        .open_row_i     (lat_row_q),
        .close_i        (bank_close),
        .close_idx_i    ({lat_bg_q, lat_ba_q}),
        .close_all_i    (close_all),
        .look_idx_i     (look_idx),
        .look_open_o    (look_open),
        .look_row_o     (look_row),
        .look_tras_ok_o (look_tras_ok),
        .any_open_o     (any_open),
        .all_tras_ok_o  (all_tras_ok)
    );

    always_comb begin
        state_d    = state_q;
        cmd        = CMD_DES;
        bank_open  = 1'b0;
        bank_close = 1'b0;
        close_all  = 1'b0;
        clr_pend   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ref_pend_q)
                    state_d = any_open ? S_PREA : S_REF;
                else if (accept) begin
                    if (!look_open)
                        state_d = S_ACT;
                    else if (look_row == req_row)
                        state_d = S_CAS;
                    else
                        state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (wait_zero && look_tras_ok) begin
                    cmd        = CMD_PRE;
                    bank_close = 1'b1;
                    state_d    = S_ACT;
                end
            end
            S_ACT: begin
                if (wait_zero) begin
                    cmd       = CMD_ACT;
                    bank_open = 1'b1;
                    state_d   = S_CAS;
                end
            end
            S_CAS: begin
                if (wait_zero) begin
                    if (lat_wr_q)
                        cmd = lat_ap_q ? CMD_WRA : CMD_WR;
                    else
                        cmd = lat_ap_q ? CMD_RDA : CMD_RD;
                    bank_close = lat_ap_q;
                    state_d    = S_IDLE;
                end
            end
            S_PREA: begin
                if (wait_zero && all_tras_ok) begin
                    cmd       = CMD_PREA;
                    close_all = 1'b1;
                    state_d   = S_REF;
                end
            end
            S_REF: begin
                if (wait_zero) begin
                    cmd      = CMD_REF;
                    clr_pend = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wait_d = wait_zero ? wait_q : wait_q - 16'd1;
        case (cmd)
            CMD_ACT:                   wait_d = W_TRCD;
            CMD_RD, CMD_WR:            wait_d = W_TCCD;
            CMD_RDA, CMD_WRA,
            CMD_PRE, CMD_PREA:         wait_d = W_TRP;
            CMD_REF:                   wait_d = W_TRFC;
            default: ;
        endcase
    end

    always_comb begin
        col_ext = '0;
        col_ext[COLWIDTH-1:0] = lat_col_q;
        pins = cmd_pins(cmd, col_ext);
        a_d = '0;
        a_d[16:0] = pins.a;
        if (cmd == CMD_ACT)
            a_d = lat_row_q;
        cs_n_d = '1;
        cs_n_d[0] = ~pins.sel;
        bank_cmd = cmd inside {CMD_ACT, CMD_PRE, CMD_RD, CMD_RDA,
                               CMD_WR, CMD_WRA};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ref_cnt_q <= (ref_cnt_q == REFI_LAST) ? 16'd0
                                                  : ref_cnt_q + 16'd1;
            if (ref_cnt_q == REFI_LAST)
                ref_pend_q <= 1'b1;
            else if (clr_pend)
                ref_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_wr_q  <= 1'b0;
            lat_ap_q  <= 1'b0;
            lat_bg_q  <= '0;
            lat_ba_q  <= '0;
            lat_row_q <= '0;
            lat_col_q <= '0;
        end else if (accept) begin
            lat_wr_q  <= req_write;
            lat_ap_q  <= req_ap;
            lat_bg_q  <= req_bg;
            lat_ba_q  <= req_ba;
            lat_row_q <= req_row;
            lat_col_q <= req_col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_q  <= '1;
            act_n_q <= 1'b1;
            a_q     <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            cs_n_q  <= cs_n_d;
            act_n_q <= pins.act_n;
            a_q     <= a_d;
            bg_q    <= bank_cmd ? lat_bg_q : '0;
            ba_q    <= bank_cmd ? lat_ba_q : '0;
            rd_q    <= (cmd == CMD_RD) || (cmd == CMD_RDA);
            wr_q    <= (cmd == CMD_WR) || (cmd == CMD_WRA);
        end
    end

    assign cs_n     = cs_n_q;
    assign act_n    = act_n_q;
    assign A        = a_q;
    assign bg       = bg_q;
    assign ba       = ba_q;
    assign rd_issue = rd_q;
    assign wr_issue = wr_q;

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Scoreboard bench for ddr4_cmd_issuer with TREFI=64: expected pin
// cycles are queued by the driver and checked by a negedge monitor.
module tb_ddr4_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        req_ap = 1'b0;
    logic [0:0]  cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        rd_issue;
    logic        wr_issue;

    ddr4_cmd_issuer #(.TREFI(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_bg    (req_bg),
        .req_ba    (req_ba),
        .req_row   (req_row),
        .req_col   (req_col),
        .req_ap    (req_ap),
        .cs_n      (cs_n),
        .act_n     (act_n),
        .A         (A),
        .bg        (bg),
        .ba        (ba),
        .rd_issue  (rd_issue),
        .wr_issue  (wr_issue)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic        act_n;
        logic [16:0] a;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic        rd;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int n_chk = 0;
    int n_fail = 0;
    int R, R2, R3;

    function automatic logic [16:0] a_cas(bit wr, logic [9:0] col, bit ap);
        logic [16:0] a;
        a = wr ? 17'h11000 : 17'h15000;
        return a | {7'd0, col} | (ap ? 17'h00400 : 17'h00000);
    endfunction

    task automatic push(int at, logic an, logic [16:0] a,
                        logic [1:0] b_g, logic [1:0] b_a, bit rd, bit wr);
        exp_t x;
        x.at = at; x.act_n = an; x.a = a;
        x.bg = b_g; x.ba = b_a; x.rd = rd; x.wr = wr;
        sb.push_back(x);
    endtask

    task automatic chk(bit ok, string nm, int act, int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: every non-DES cycle must match the head of the queue.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missed_cmd: nothing at cyc %0d, required A=%h act_n=%b",
                     e.at, e.a, e.act_n);
        end
        n_chk++;
        if (cs_n !== 1'b1) begin
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cmd cyc=%0d: got cs_n=%b act_n=%b A=%h bg=%0d ba=%0d, required DES",
                         cyc, cs_n, act_n, A, bg, ba);
            end else begin
                e = sb.pop_front();
                if (cs_n !== 1'b0 || cyc != e.at || act_n !== e.act_n ||
                    A !== e.a || bg !== e.bg || ba !== e.ba ||
                    rd_issue !== e.rd || wr_issue !== e.wr) begin
                    n_fail++;
                    $display("FAIL cmd: got cyc=%0d act_n=%b A=%h bg=%0d ba=%0d rd=%b wr=%b, required cyc=%0d act_n=%b A=%h bg=%0d ba=%0d rd=%b wr=%b",
                             cyc, act_n, A, bg, ba, rd_issue, wr_issue,
                             e.at, e.act_n, e.a, e.bg, e.ba, e.rd, e.wr);
                end
            end
        end else if (act_n !== 1'b1 || A !== '0 || bg !== '0 ||
                     ba !== '0 || rd_issue !== 1'b0 || wr_issue !== 1'b0) begin
            n_fail++;
            $display("FAIL des cyc=%0d: got act_n=%b A=%h bg=%0d ba=%0d rd=%b wr=%b, required DES zeros",
                     cyc, act_n, A, bg, ba, rd_issue, wr_issue);
        end
    end

    task automatic send(bit wr, logic [1:0] b_g, logic [1:0] b_a,
                        logic [16:0] row, logic [9:0] col, bit ap,
                        int exp_acc, string nm);
        int acc;
        acc = -1;
        req_write = wr; req_bg = b_g; req_ba = b_a;
        req_row = row; req_col = col; req_ap = ap;
        req_valid = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (req_ready === 1'b1) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc >= 0) begin
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk(acc == exp_acc, nm, acc, exp_acc);
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk(req_ready === 1'b0, "ready_in_reset", int'(req_ready), 0);
        reset = 1'b0;
        R = cyc + 1;
        #1;

        // closed bank read
        send(0, 2'd1, 2'd2, 17'h001A5, 10'h03C, 0, R, "acc_rd1");
        push(R + 1, 1'b0, 17'h001A5, 2'd1, 2'd2, 0, 0);
        push(R + 15, 1'b1, a_cas(0, 10'h03C, 0), 2'd1, 2'd2, 1, 0);

        // row-hit write, TCCD after the read
        send(1, 2'd1, 2'd2, 17'h001A5, 10'h2A0, 0, R + 16, "acc_wr_hit");
        push(R + 19, 1'b1, a_cas(1, 10'h2A0, 0), 2'd1, 2'd2, 0, 1);

        // row miss: PRE at ACT+TRAS, ACT +TRP, RD +TRCD
        send(0, 2'd1, 2'd2, 17'h00002, 10'h011, 0, R + 20, "acc_rd_miss");
        push(R + 33, 1'b1, 17'h08000, 2'd1, 2'd2, 0, 0);
        push(R + 47, 1'b0, 17'h00002, 2'd1, 2'd2, 0, 0);
        push(R + 61, 1'b1, a_cas(0, 10'h011, 0), 2'd1, 2'd2, 1, 0);

        // refresh falls due with bank open
        wait_cyc(R + 63);
        chk(req_ready === 1'b0, "ready_ref_pending", int'(req_ready), 0);
        push(R + 79, 1'b1, 17'h08400, 2'd0, 2'd0, 0, 0);
        push(R + 93, 1'b1, 17'h04000, 2'd0, 2'd0, 0, 0);
        send(0, 2'd1, 2'd2, 17'h00002, 10'h007, 0, R + 94, "acc_after_ref");
        push(R + 353, 1'b0, 17'h00002, 2'd1, 2'd2, 0, 0);
        push(R + 367, 1'b1, a_cas(0, 10'h007, 0), 2'd1, 2'd2, 1, 0);

        wait_cyc(R + 367);
        reset = 1'b1;
        @(negedge clk);
        chk(req_ready === 1'b0, "ready_in_reset2", int'(req_ready), 0);
        reset = 1'b0;
        R2 = cyc + 1;
        #1;

        // auto-precharge read then same bank: ACT TRP after RDA
        send(0, 2'd2, 2'd1, 17'h00055, 10'h010, 1, R2, "acc_rda");
        push(R2 + 1, 1'b0, 17'h00055, 2'd2, 2'd1, 0, 0);
        push(R2 + 15, 1'b1, a_cas(0, 10'h010, 1), 2'd2, 2'd1, 1, 0);
        send(0, 2'd2, 2'd1, 17'h00055, 10'h011, 0, R2 + 16, "acc_after_rda");
        push(R2 + 29, 1'b0, 17'h00055, 2'd2, 2'd1, 0, 0);
        push(R2 + 43, 1'b1, a_cas(0, 10'h011, 0), 2'd2, 2'd1, 1, 0);

        // reset between ACT and RD
        send(0, 2'd0, 2'd3, 17'h00077, 10'h005, 0, R2 + 44, "acc_pre_reset");
        push(R2 + 47, 1'b0, 17'h00077, 2'd0, 2'd3, 0, 0);
        wait_cyc(R2 + 47);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk(req_ready === 1'b1, "ready_after_reset", int'(req_ready), 1);
        R3 = cyc + 1;
        send(0, 2'd0, 2'd3, 17'h00077, 10'h005, 0, R3, "acc_post_reset");
        push(R3 + 1, 1'b0, 17'h00077, 2'd0, 2'd3, 0, 0);
        push(R3 + 15, 1'b1, a_cas(0, 10'h005, 0), 2'd0, 2'd3, 1, 0);

        wait_cyc(R3 + 45);
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
